// File: rtl/imem_pkg.sv
// imem_pkg: shared widths, the response record and the address check for the
// instruction-memory responder and its response FIFO.
package imem_pkg;

  localparam int IMEM_ADDR_W = 32;
  localparam int IMEM_DATA_W = 32;

  // One response as it travels through the pipeline and the FIFO.
  typedef struct packed {
    logic                   err;
    logic [IMEM_DATA_W-1:0] data;
  } imem_resp_t;

  // A fetch is bad when it is not word aligned or its word index is past the array.
  function automatic logic imem_addr_err(input logic [IMEM_ADDR_W-1:0] addr,
                                         input int unsigned            depth);
    logic [IMEM_ADDR_W-1:0] word_idx;
    word_idx = {2'b00, addr[IMEM_ADDR_W-1:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// imem_resp_fifo: show-ahead synchronous FIFO of imem_resp_t. The head entry is
// visible on pop_data whenever empty is low; pointers wrap modulo DEPTH.
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  imem_resp_t                 push_data,
  input  logic                       pop,
  output imem_resp_t                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  imem_resp_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; the storage itself is never reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Callers must never push into a full FIFO.
  assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/imem_responder.sv
// imem_responder: serves word-aligned fetch requests from an internal word array.
// Requests flow through a LATENCY-deep {valid, err, data} pipeline (array read in
// stage 1) into a show-ahead response FIFO; a credit counter keeps the FIFO from
// ever overflowing. When the FIFO is empty the pipeline output is presented
// directly, so an accepted request is visible LATENCY cycles later.
// Optional: define IMEM_RESPONDER_PERF_EN to add perf_req_cnt / perf_stall_cnt.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W          = IMEM_ADDR_W,
  parameter int DATA_W          = IMEM_DATA_W,
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 2,
  parameter int RESP_FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_W-1:0]              req_addr,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [DATA_W-1:0]              resp_data,
  output logic                           resp_err,
  input  logic                           load_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [DATA_W-1:0]              load_data
`ifdef IMEM_RESPONDER_PERF_EN
  ,
  output logic [31:0]                    perf_req_cnt,
  output logic [31:0]                    perf_stall_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(RESP_FIFO_DEPTH + 1);

  logic [DATA_W-1:0]  mem [DEPTH_WORDS];
  logic [DATA_W-1:0]  mem_rdata_q;
  logic               accept, req_err, rd_en, resp_pop;
  logic [IDX_W-1:0]   rd_idx;
  logic               s1_valid_q, s1_valid_d, s1_err_q, s1_err_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic               req_ready_q, req_ready_d;
  logic [LATENCY-1:0] stage_valid;
  imem_resp_t         stage_resp [LATENCY];
  logic               pipe_valid;
  imem_resp_t         pipe_resp, fifo_head, resp_head;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  assign accept  = req_valid && req_ready_q;
  assign req_err = imem_addr_err(req_addr, DEPTH_WORDS);
  assign rd_en   = accept && !req_err;
  assign rd_idx  = req_addr[2 +: IDX_W];

  // Array port: preload write and stage-1 read; a same-word read sees the old word.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
    if (rd_en)   mem_rdata_q    <= mem[rd_idx];
  end

  // Stage-1 control and the credit counter; ready depends on registers only.
  always_comb begin
    s1_valid_d    = accept;
    s1_err_d      = accept && req_err;
    outstanding_d = outstanding_q;
    case ({accept, resp_pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    req_ready_d = (outstanding_d < CNT_W'(RESP_FIFO_DEPTH));
  end

  // Control registers; req_ready is held low in reset and rises on the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_err_q      <= 1'b0;
      outstanding_q <= '0;
      req_ready_q   <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_err_q      <= s1_err_d;
      outstanding_q <= outstanding_d;
      req_ready_q   <= req_ready_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign stage_valid[0] = s1_valid_q;
  assign stage_resp[0]  = '{err: s1_err_q, data: s1_err_q ? '0 : mem_rdata_q};

  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
    logic       valid_q;
    imem_resp_t resp_q;
    // Delay stage between the array read and the FIFO.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        resp_q  <= '0;
      end else begin
        valid_q <= stage_valid[gi-1];
        resp_q  <= stage_resp[gi-1];
      end
    end
    assign stage_valid[gi] = valid_q;
    assign stage_resp[gi]  = resp_q;
  end

  assign pipe_valid = stage_valid[LATENCY-1];
  assign pipe_resp  = stage_resp[LATENCY-1];

  // Head selection: FIFO head if occupied, else the pipeline output, else zeros.
  always_comb begin
    resp_head = '0;
    if (!fifo_empty)     resp_head = fifo_head;
    else if (pipe_valid) resp_head = pipe_resp;
  end

  assign resp_valid = !fifo_empty || pipe_valid;
  assign resp_data  = resp_head.data;
  assign resp_err   = resp_head.err;
  assign resp_pop   = resp_valid && resp_ready;
  assign fifo_pop   = !fifo_empty && resp_ready;
  assign fifo_push  = pipe_valid && !(fifo_empty && resp_ready);

  imem_resp_fifo #(.DEPTH(RESP_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (pipe_resp),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Credits cover everything queued, so a push into a full FIFO cannot occur.
  assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));
  assert property (@(posedge clk) disable iff (rst) outstanding_q >= fifo_count);

`ifdef IMEM_RESPONDER_PERF_EN
  logic [31:0] perf_req_cnt_q, perf_req_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  // Saturating counts of accepted requests and of stalled request cycles.
  always_comb begin
    perf_req_cnt_d   = perf_req_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (accept && (perf_req_cnt_q != '1))
      perf_req_cnt_d = perf_req_cnt_q + 32'd1;
    if (req_valid && !req_ready_q && (perf_stall_cnt_q != '1))
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_req_cnt_q   <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_req_cnt_q   <= perf_req_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_req_cnt   = perf_req_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed plus randomized fetch traffic against a word-array
// reference model; expected responses are queued at accept and checked by a
// separate monitor in order.
module tb_imem_responder;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        load_we = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  imem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a fetch returns the stored word, or err with zero data when the
  // address is misaligned or beyond the array.
  function automatic exp_t model_resp(input logic [31:0] addr, input bit chk);
    exp_t        e;
    int unsigned w;
    w         = addr / 4;
    e.err     = (addr % 4 != 0) || (w >= DEPTH);
    e.data    = 32'h0;
    if (!e.err) e.data = model_mem[w];
    e.acc_cyc = cyc;
    e.chk_lat = chk;
    return e;
  endfunction

  // One clock of stimulus; inputs change just after the rising edge.
  task automatic drive(input bit rv, input logic [31:0] addr, input bit lw,
                       input logic [9:0] la, input logic [31:0] ld, input bit rr,
                       input bit chk, output bit acc);
    req_valid  = rv;
    req_addr   = addr;
    load_we    = lw;
    load_addr  = la;
    load_data  = ld;
    resp_ready = rr;
    @(negedge clk);
    acc = rv && (req_ready === 1'b1);
    if (acc) exp_q.push_back(model_resp(addr, chk));
    if (lw) model_mem[la] = ld;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    load_we   = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    resp_ready = 1'b1;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_complete", exp_q.size(), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares every presented response with the scoreboard head.
  initial begin : monitor
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_err;
    exp_t        e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (resp_valid === 1'b1) begin
        if (prev_stall) begin
          check("held_data", resp_data, prev_data);
          check("held_err", resp_err, prev_err);
        end
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          e = exp_q[0];
          if (!prev_stall && e.chk_lat) check("latency", cyc - e.acc_cyc, LATENCY);
          check("resp_data", resp_data, e.data);
          check("resp_err", resp_err, e.err);
          if (resp_ready) void'(exp_q.pop_front());
        end
        prev_stall = !resp_ready;
        prev_data  = resp_data;
        prev_err   = resp_err;
      end else begin
        if (prev_stall) check("resp_dropped", 0, 1);
        if (resp_data !== 32'h0 || resp_err !== 1'b0)
          check("idle_zero", {resp_err, resp_data}, 0);
        prev_stall = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit          acc;
    int          accepted;
    int          rst_bad;
    int          r;
    logic [31:0] addr;
    logic [31:0] words [4];
    words[0] = 32'h00000013;
    words[1] = 32'h00100093;
    words[2] = 32'h00200113;
    words[3] = 32'h00300193;

    // Preload the whole array while reset is held; outputs must stay quiet.
    rst_bad = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 32'h0, 1, 10'(i), (i < 4) ? words[i] : 32'h0, 0, 0, acc);
      if (resp_valid !== 1'b0 || req_ready !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0)
        rst_bad++;
    end
    check("reset_outputs", rst_bad, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", req_ready, 1);

    // Back-to-back fetch of words 0..3.
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'(k * 4), 0, 0, 0, 1, k == 0, acc);
      check("b2b_accept", acc, 1);
    end
    drain(20);

    // Backpressure: six offers, only four credits.
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1, 32'(k * 4), 0, 0, 0, 0, 0, acc);
      accepted += int'(acc);
    end
    check("bp_accepted", accepted, 4);
    check("bp_ready_low", req_ready, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_before_pop", req_ready, 0);
    @(posedge clk);
    #1;
    check("bp_ready_after_pop", req_ready, 1);
    drain(20);

    // Error responses followed by a good fetch.
    drive(1, 32'h2, 0, 0, 0, 1, 1, acc);
    check("err_misaligned_accept", acc, 1);
    drive(1, 32'h1000, 0, 0, 0, 1, 0, acc);
    check("err_range_accept", acc, 1);
    drive(1, 32'h4, 0, 0, 0, 1, 0, acc);
    drain(20);

    // Same-edge preload and read of word 5 returns the old word.
    drive(1, 32'h14, 1, 10'd5, 32'hDEADBEEF, 1, 1, acc);
    check("collision_accept", acc, 1);
    drain(20);
    drive(1, 32'h14, 0, 0, 0, 1, 0, acc);
    drain(20);

    // Randomized traffic, preloads and backpressure.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       addr = 32'($urandom_range(0, 31)) * 4;
      else if (r == 8) addr = 32'($urandom_range(0, 127)) * 4 + 32'($urandom_range(1, 3));
      else             addr = 32'h1000 + 32'($urandom_range(0, 4000)) * 4;
      drive($urandom_range(0, 9) < 7, addr, $urandom_range(0, 4) == 0,
            10'($urandom_range(8, 31)), $urandom, $urandom_range(0, 9) < 6, 0, acc);
    end
    drain(50);

    // Reset with three responses queued: they must vanish at once.
    for (int k = 0; k < 3; k++) drive(1, 32'(k * 4), 0, 0, 0, 0, 0, acc);
    for (int k = 0; k < 3; k++) drive(0, 32'h0, 0, 0, 0, 0, 0, acc);
    check("midrst_queued", resp_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid_drop", resp_valid, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready", req_ready, 1);
    for (int k = 0; k < 5; k++) drive(0, 32'h0, 0, 0, 0, 1, 0, acc);
    accepted = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'(k * 4), 0, 0, 0, 0, 0, acc);
      accepted += int'(acc);
    end
    check("midrst_credits", accepted, 4);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder and the serving end of the fetch request/response channel.
- Accepts word-aligned fetch requests over a valid/ready handshake and reads an internal word array.
- Returns instruction words in order, after a fixed pipeline latency, through a credit-limited response FIFO that absorbs fetch-side backpressure.
- Sits between instruction_fetch and the instruction storage. It also has a preload port used by bench and boot.

Parameters:
- ADDR_W, 32: byte-address width.
- DATA_W, 32: instruction word width.
- DEPTH_WORDS, 1024: number of words in the array; power of 2.
- LATENCY, 2: cycles from request accept to response visible; legal range 1..4.
- RESP_FIFO_DEPTH, 4: response FIFO entries; must be >= LATENCY.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  ADDR_W  byte address of the instruction.
- resp_valid  out  1  response word available at the FIFO head.
- resp_ready  in  1  fetch consumes the response.
- resp_data  out  DATA_W  instruction word.
- resp_err  out  1  request was misaligned or out of range.
- load_we  in  1  preload write enable.
- load_addr  in  $clog2(DEPTH_WORDS)  word index for preload.
- load_data  in  DATA_W  preload word.

Behaviour:
- Reset (asynchronous, active-high): clears pipeline valid bits, FIFO pointers/count and the outstanding counter. The array is NOT reset and keeps its contents.
- Outputs during reset: req_ready=0, resp_valid=0, resp_data=0, resp_err=0. req_ready rises the first cycle after rst deasserts.
- Accept: a request is accepted on an edge where req_valid && req_ready.
- Error check at accept:
  - err = (req_addr[1:0]!=0) || (req_addr[ADDR_W-1:2] >= DEPTH_WORDS).
  - On err, data=0 and the array is not indexed.
- Latency: the accepted request travels through a LATENCY-deep pipeline of {valid, data, err}. The array read is synchronous in stage 1.
  - The pipeline output pushes into the FIFO.
  - The FIFO is show-ahead: its head drives resp_data/resp_err combinationally.
  - A request accepted at edge N shows resp_valid=1 in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles later, when the FIFO was empty.
- Ordering: responses always leave in request order.
- Credit / flow control:
  - outstanding = in-flight pipeline entries + FIFO count, held in a registered counter.
  - req_ready = (outstanding < RESP_FIFO_DEPTH). It is computed from registers only, with no combinational path from resp_ready.
  - Counter update: +1 on accept, -1 on pop (resp_valid && resp_ready). Accept and pop on the same edge leave it unchanged.
  - The FIFO can therefore never overflow. Pushing into a full FIFO is an assertion failure.
- Response handshake:
  - resp_data and resp_err hold stable while resp_valid && !resp_ready.
  - Pop happens on resp_valid && resp_ready.
  - An empty FIFO drives resp_valid=0, with data and err both 0.
- Preload:
  - load_we writes load_data to array[load_addr] on the edge.
  - If a same-edge read hits the same word, the read returns the OLD data (read-before-write).
- FIFO wrap-around: pointers are $clog2(RESP_FIFO_DEPTH) bits wide and wrap modulo depth.
- Mid-operation reset: all in-flight and queued responses are dropped and nothing is emitted for them.

Optional Feature:
- Macro IMEM_RESPONDER_PERF_EN.
- When defined:
  - Adds output ports perf_req_cnt[31:0], counting accepted requests, and perf_stall_cnt[31:0], counting cycles with req_valid && !req_ready.
  - Both counters saturate at all-ones and clear on rst.
- When undefined: the ports and counters do not exist and the remaining behaviour is identical.

Decomposition:
- Package imem_pkg holds:
  - IMEM_ADDR_W and IMEM_DATA_W constants.
  - typedef imem_resp_t {logic err; logic [DATA_W-1:0] data;}.
  - Function imem_addr_err(addr, depth).
- Sub-module imem_resp_fifo: a generic show-ahead synchronous FIFO of imem_resp_t with push, pop, full, empty and count.

Test Plan:
- Reset check: preload array[0..3]=32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193, then release rst.
  - req_ready=1 the first cycle after release.
  - resp_valid=0 throughout reset.
- Back-to-back fetch: requests 0x0, 0x4, 0x8, 0xC on consecutive cycles with resp_ready=1.
  - Responses 13, 100093, 200113, 300193 arrive in order.
  - The first response is visible 2 cycles after its accept.
- Backpressure: resp_ready=0 with 6 requests offered.
  - Exactly 4 are accepted and req_ready stays low afterwards.
  - Raising resp_ready drains the 4 in order, and req_ready reasserts the cycle after the first pop.
- Errors:
  - req_addr=0x2 gives resp_err=1, data=0.
  - req_addr=0x1000 (word 1024, DEPTH_WORDS=1024) gives resp_err=1.
  - The following valid request 0x4 returns 100093 with err=0.
- Collision: load_we writing array[5]=32'hDEADBEEF on the same edge a request for 0x14 (old value 32'h0) is accepted.
  - The response is 0.
  - A later request for 0x14 returns DEADBEEF.
- Mid-operation reset: assert rst while 3 responses are queued.
  - resp_valid drops immediately (asynchronous).
  - After release, outstanding=0, no stale responses appear, and array[0] still reads 32'h00000013.
